// File: rtl/calculator_ctrl.sv
// calculator_ctrl: sequencing controller for the hex calculator.
// Turns debounced key levels into operand entry, runs add/sub/mul/div on a
// shared iterative datapath and drives the display value and error flag.
//
// Ports:
//   clk_g      system clock
//   rst_n      asynchronous active-low reset
//   digit_key  digit key level; rising edge shifts digit_in into the entry
//   digit_in   hex digit value
//   op_key     operator key level; rising edge selects op_in
//   op_in      operator: 00 add, 01 sub, 10 mul, 11 div
//   eq_key     equals key level; rising edge starts execution
//   clr_key    clear key level; rising edge clears everything
//   cal_result value to display (registered)
//   error      high while in ERR (registered)
//   busy       high while in BUSY (registered)
module calculator_ctrl #(
    parameter int unsigned ITER = 32
) (
    input  logic        clk_g,
    input  logic        rst_n,
    input  logic        digit_key,
    input  logic [3:0]  digit_in,
    input  logic        op_key,
    input  logic [1:0]  op_in,
    input  logic        eq_key,
    input  logic        clr_key,
    output logic [31:0] cal_result,
    output logic        error,
    output logic        busy
);

    typedef enum logic [2:0] {ENTER_A, ENTER_B, BUSY, DONE, ERR} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

    localparam logic [5:0] CNT_LAST = 6'(ITER - 1);

    state_t      state;
    op_t         op;
    logic [31:0] entry;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [5:0]  cnt;
    logic [63:0] acc;

    logic digit_q, op_q, eq_q, clr_q;
    logic digit_e, op_e, eq_e, clr_e;
    logic digit_act, op_act, eq_act;

    logic [32:0] add_sum;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_trial;
    logic [63:0] div_next;
    logic        last;

    assign digit_e = digit_key & ~digit_q;
    assign op_e    = op_key    & ~op_q;
    assign eq_e    = eq_key    & ~eq_q;
    assign clr_e   = clr_key   & ~clr_q;

    // Only the highest-priority edge acts; a masked lower edge is lost even
    // when the winning edge is ignored in the current state.
    assign eq_act    = eq_e & ~clr_e;
    assign op_act    = op_e & ~eq_e & ~clr_e;
    assign digit_act = digit_e & ~op_e & ~eq_e & ~clr_e;

    assign last = (cnt == CNT_LAST);

    always_comb begin
        add_sum  = {1'b0, opa} + {1'b0, opb};
        // Multiply: acc = {partial product, remaining multiplier bits}.
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opa} : 33'd0);
        mul_next = {mul_sum, acc[31:1]};
        // Restoring divide: acc = {remainder, dividend/quotient}.
        div_trial = acc[63:31] - {1'b0, opb};
        if (div_trial[32]) begin
            div_next = {acc[62:0], 1'b0};
        end else begin
            div_next = {div_trial[31:0], acc[30:0], 1'b1};
        end
    end

    always_ff @(posedge clk_g or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ENTER_A;
            op         <= OP_ADD;
            entry      <= '0;
            opa        <= '0;
            opb        <= '0;
            cnt        <= '0;
            acc        <= '0;
            digit_q    <= 1'b0;
            op_q       <= 1'b0;
            eq_q       <= 1'b0;
            clr_q      <= 1'b0;
            cal_result <= '0;
            error      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            digit_q <= digit_key;
            op_q    <= op_key;
            eq_q    <= eq_key;
            clr_q   <= clr_key;

            if (clr_e) begin
                state      <= ENTER_A;
                op         <= OP_ADD;
                entry      <= '0;
                opa        <= '0;
                opb        <= '0;
                cnt        <= '0;
                acc        <= '0;
                cal_result <= '0;
                error      <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    ENTER_A: begin
                        if (op_act) begin
                            opa        <= entry;
                            op         <= op_t'(op_in);
                            entry      <= '0;
                            cal_result <= '0;
                            state      <= ENTER_B;
                        end else if (digit_act) begin
                            entry      <= {entry[27:0], digit_in};
                            cal_result <= {entry[27:0], digit_in};
                        end
                    end
                    ENTER_B: begin
                        if (eq_act) begin
                            opb   <= entry;
                            cnt   <= '0;
                            acc   <= (op == OP_MUL) ? {32'd0, entry} : {32'd0, opa};
                            busy  <= 1'b1;
                            state <= BUSY;
                        end else if (op_act) begin
                            op <= op_t'(op_in);
                        end else if (digit_act) begin
                            entry      <= {entry[27:0], digit_in};
                            cal_result <= {entry[27:0], digit_in};
                        end
                    end
                    BUSY: begin
                        case (op)
                            OP_ADD: begin
                                busy <= 1'b0;
                                if (add_sum[32]) begin
                                    state      <= ERR;
                                    error      <= 1'b1;
                                    cal_result <= '0;
                                end else begin
                                    state      <= DONE;
                                    cal_result <= add_sum[31:0];
                                end
                            end
                            OP_SUB: begin
                                busy <= 1'b0;
                                if (opa < opb) begin
                                    state      <= ERR;
                                    error      <= 1'b1;
                                    cal_result <= '0;
                                end else begin
                                    state      <= DONE;
                                    cal_result <= opa - opb;
                                end
                            end
                            OP_MUL: begin
                                acc <= mul_next;
                                cnt <= cnt + 6'd1;
                                if (last) begin
                                    busy <= 1'b0;
                                    if (mul_next[63:32] != 32'd0) begin
                                        state      <= ERR;
                                        error      <= 1'b1;
                                        cal_result <= '0;
                                    end else begin
                                        state      <= DONE;
                                        cal_result <= mul_next[31:0];
                                    end
                                end
                            end
                            default: begin
                                if (cnt == 6'd0 && opb == 32'd0) begin
                                    busy       <= 1'b0;
                                    state      <= ERR;
                                    error      <= 1'b1;
                                    cal_result <= '0;
                                end else begin
                                    acc <= div_next;
                                    cnt <= cnt + 6'd1;
                                    if (last) begin
                                        busy       <= 1'b0;
                                        state      <= DONE;
                                        cal_result <= div_next[31:0];
                                    end
                                end
                            end
                        endcase
                    end
                    DONE: begin
                        if (op_act) begin
                            opa        <= cal_result;
                            op         <= op_t'(op_in);
                            entry      <= '0;
                            cal_result <= '0;
                            state      <= ENTER_B;
                        end else if (digit_act) begin
                            entry      <= {28'd0, digit_in};
                            cal_result <= {28'd0, digit_in};
                            state      <= ENTER_A;
                        end
                    end
                    default: begin
                        // ERR: held until a clear edge.
                        state <= ERR;
                    end
                endcase
            end
        end
    end

endmodule
